// File: rtl/sorting_pkg.sv
// Shared sizing defaults and element type for the streaming sort engine.
package sorting_pkg;
    localparam int N_DEFAULT = 10;
    localparam int W_DEFAULT = 16;

    typedef logic [W_DEFAULT-1:0] elem_t;
endpackage

// File: rtl/sort_phase.sv
// One transposition layer: compare-swap on even pairs (0,1),(2,3),... or odd pairs (1,2),(3,4),...
module sort_phase
    import sorting_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter int W         = W_DEFAULT,
    parameter bit PHASE_ODD = 1'b0
) (
    input  logic [N*W-1:0] x_i,
    output logic [N*W-1:0] x_o
);

    localparam int FIRST = PHASE_ODD ? 1 : 0;

    // Equal values are left in place, so equal keys are never swapped.
    always_comb begin
        x_o = x_i;
        for (int i = FIRST; i + 1 < N; i += 2) begin
            if (x_i[i*W +: W] > x_i[(i+1)*W +: W]) begin
                x_o[i*W +: W]     = x_i[(i+1)*W +: W];
                x_o[(i+1)*W +: W] = x_i[i*W +: W];
            end
        end
    end

endmodule

// File: rtl/sorting.sv
// Fully pipelined odd-even transposition sorter: N compare-swap phases, each followed by a register.
module sorting
    import sorting_pkg::*;
#(
    parameter int N = N_DEFAULT,
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] a     [N-1:0],
    output logic         out_valid,
    output logic [W-1:0] array [N-1:0]
);

    logic [N*W-1:0] a_flat;
    logic [N*W-1:0] data_d [N];
    logic [N*W-1:0] data_q [N];
    logic [N-1:0]   valid_q;

    always_comb begin
        a_flat = '0;
        for (int k = 0; k < N; k++) begin
            a_flat[k*W +: W] = a[k];
        end
    end

    // data_q[s] holds the result of phase s; phase 0 works on the raw input.
    for (genvar s = 0; s < N; s++) begin : g_stage
        if (s == 0) begin : g_first
            sort_phase #(.N(N), .W(W), .PHASE_ODD(1'b0)) u_phase (
                .x_i (a_flat),
                .x_o (data_d[s])
            );
        end else begin : g_rest
            sort_phase #(.N(N), .W(W), .PHASE_ODD(s % 2 == 1)) u_phase (
                .x_i (data_q[s-1]),
                .x_o (data_d[s])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < N; s++) begin
                data_q[s] <= '0;
            end
            valid_q <= '0;
        end else begin
            for (int s = 0; s < N; s++) begin
                data_q[s] <= data_d[s];
            end
            valid_q <= {valid_q[N-2:0], in_valid};
        end
    end

    always_comb begin
        for (int k = 0; k < N; k++) begin
            array[k] = data_q[N-1][k*W +: W];
        end
    end

    assign out_valid = valid_q[N-1];

endmodule

// File: tb/tb_sorting.sv
// Self-checking bench for the sorter: directed scenarios plus random streaming against a sort reference.
module tb_sorting;
    import sorting_pkg::*;

    localparam int N    = N_DEFAULT;
    localparam int MAXC = 400;

    logic  clk = 1'b0;
    logic  rst;
    logic  in_valid;
    elem_t a     [N-1:0];
    logic  out_valid;
    elem_t array [N-1:0];

    int    n_assert = 0;
    int    n_fail   = 0;
    int    e        = 0;
    int    last_rst = -1000;
    logic  hist_v [MAXC];
    elem_t hist_a [MAXC][N];

    sorting #(.N(N), .W(W_DEFAULT)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .out_valid (out_valid),
        .array     (array)
    );

    always #5 clk = ~clk;

    function automatic void ref_sort(input elem_t v[N], output elem_t r[N]);
        elem_t t;
        r = v;
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0 && r[j-1] > r[j]; j--) begin
                t = r[j]; r[j] = r[j-1]; r[j-1] = t;
            end
        end
    endfunction

    // The output after edge t belongs to the vector captured at edge t-(N-1),
    // unless a reset edge fell between then and now.
    task automatic check_edge(input int t);
        int    k;
        elem_t exp_v [N];
        k = t - (N - 1);
        if (last_rst >= k) begin
            n_assert++;
            assert (out_valid === 1'b0) else begin
                n_fail++;
                $error("FAIL rst_valid edge=%0d got=%b exp=0", t, out_valid);
            end
            for (int j = 0; j < N; j++) begin
                n_assert++;
                assert (array[j] === '0) else begin
                    n_fail++;
                    $error("FAIL rst_data edge=%0d idx=%0d got=%0d exp=0", t, j, array[j]);
                end
            end
        end else begin
            n_assert++;
            assert (out_valid === hist_v[k]) else begin
                n_fail++;
                $error("FAIL out_valid edge=%0d got=%b exp=%b", t, out_valid, hist_v[k]);
            end
            if (hist_v[k]) begin
                ref_sort(hist_a[k], exp_v);
                for (int j = 0; j < N; j++) begin
                    n_assert++;
                    assert (array[j] === exp_v[j]) else begin
                        n_fail++;
                        $error("FAIL data edge=%0d idx=%0d got=%0d exp=%0d", t, j, array[j], exp_v[j]);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (e < MAXC) begin
            hist_v[e] = in_valid;
            for (int k = 0; k < N; k++) hist_a[e][k] = a[k];
            if (rst) last_rst = e;
        end
        #1;
        if (e < MAXC) check_edge(e);
        e++;
    endtask

    task automatic put(input elem_t v[N], input logic vld);
        for (int k = 0; k < N; k++) a[k] = v[k];
        in_valid = vld;
        tick();
    endtask

    task automatic rand_vec(output elem_t v[N], input int mode);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0:       v[k] = elem_t'($urandom);
                1:       v[k] = elem_t'($urandom % 500 + 500);
                default: v[k] = elem_t'($urandom % 8);
            endcase
        end
    endtask

    task automatic idle(input int cycles);
        elem_t v [N];
        for (int c = 0; c < cycles; c++) begin
            rand_vec(v, 0);
            put(v, 1'b0);
        end
    endtask

    initial begin
        elem_t v [N];
        elem_t single [N] = '{510, 3, 999, 0, 250, 250, 65535, 1, 700, 42};

        rst = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < N; k++) a[k] = '0;

        // Reset with live-looking input, then watch the pipeline stay empty.
        rand_vec(v, 0); put(v, 1'b1);
        rand_vec(v, 0); put(v, 1'b1);
        rst = 1'b0;
        idle(N);

        put(single, 1'b1);
        idle(N + 1);

        for (int k = 0; k < N; k++) v[k] = elem_t'(N - 1 - k);
        put(v, 1'b1);
        for (int k = 0; k < N; k++) v[k] = elem_t'(k);
        put(v, 1'b1);
        for (int k = 0; k < N; k++) v[k] = elem_t'(7);
        put(v, 1'b1);
        idle(N);

        for (int c = 0; c < 3; c++) begin
            rand_vec(v, 1); put(v, 1'b1);
        end
        idle(N);

        rand_vec(v, 1); put(v, 1'b1);
        rand_vec(v, 1); put(v, 1'b0);
        rand_vec(v, 1); put(v, 1'b1);
        idle(N);

        // Five vectors in flight, then a reset that must discard them.
        for (int c = 0; c < 5; c++) begin
            rand_vec(v, 0); put(v, 1'b1);
        end
        rst = 1'b1;
        rand_vec(v, 0); put(v, 1'b1);
        rst = 1'b0;
        rand_vec(v, 1); put(v, 1'b1);
        idle(N + 1);

        for (int c = 0; c < 80; c++) begin
            rand_vec(v, c % 2 == 0 ? 0 : 2);
            put(v, logic'($urandom % 4 != 0));
        end
        idle(N + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
